// File: rtl/keypad_digit_loader_if.sv
// Keypad-side bundle of the digit loader: raw key lines and lock in, BCD digit and load strobe out.
// Strobe contract: loadn is low for exactly one clock per accepted key; data_out is valid in that cycle and holds afterwards.
interface keypad_digit_loader_if;
  logic [9:0] keypad;
  logic       lock;
  logic [3:0] data_out;
  logic       loadn;
  logic       busy;
  logic [1:0] dbg_state;

  modport master (
    output keypad,
    output lock,
    input  data_out,
    input  loadn,
    input  busy,
    input  dbg_state
  );

  modport slave (
    input  keypad,
    input  lock,
    output data_out,
    output loadn,
    output busy,
    output dbg_state
  );
endinterface

// File: rtl/keypad_digit_loader.sv
// Debounces a 10-key decimal keypad, rejects multi-key presses and emits one BCD digit plus
// an active-low load strobe per accepted key for the countdown timer.
module keypad_digit_loader #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input logic                  clock,
  input logic                  clear,
  keypad_digit_loader_if.slave kp
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESS   = 2'd1,
    LOAD    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       code_q, code_d;
  logic [9:0]       pat_q, pat_d;
  logic [3:0]       data_out_q, data_out_d;
  logic             loadn_q, loadn_d;
  logic             busy_q, busy_d;

  logic             single_key;
  logic [3:0]       key_code;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    key_code = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (kp.keypad[i]) key_code = 4'(i);
    end
  end

  assign single_key = $onehot(kp.keypad);
  // Saturating increment: the counter never wraps even if a state lingers.
  assign cnt_inc    = (cnt_q == DB_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    pat_d      = pat_q;
    data_out_d = data_out_q;
    loadn_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!kp.lock && single_key) begin
          code_d  = key_code;
          pat_d   = kp.keypad;
          cnt_d   = CNT_W'(1);
          state_d = PRESS;
        end
      end
      PRESS: begin
        // The detection cycle in IDLE already counted as the first stable cycle.
        if ((kp.keypad != pat_q) || kp.lock) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_MAX) begin
            state_d    = LOAD;
            loadn_d    = 1'b0;
            data_out_d = code_q;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RELEASE;
      end
      RELEASE: begin
        if (kp.keypad == 10'd0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == DB_MAX) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = '0;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= 4'd0;
      pat_q      <= 10'd0;
      data_out_q <= 4'd0;
      loadn_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      pat_q      <= pat_d;
      data_out_q <= data_out_d;
      loadn_q    <= loadn_d;
      busy_q     <= busy_d;
    end
  end

  assign kp.data_out  = data_out_q;
  assign kp.loadn     = loadn_q;
  assign kp.busy      = busy_q;
  assign kp.dbg_state = state_q;

endmodule
